// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/LATCH/HOLD control of PC and IR,
// with a small return-address stack driving call/return next-PC selection.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        stall,
  input  logic        pc_update,
  input  logic [1:0]  pc_src,
  input  logic        push_ret,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        instr_valid,
  output logic        busy,
  output logic [4:0]  ras_count,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam int unsigned AW    = $clog2(RAS_DEPTH);
  localparam logic [4:0]  DEPTH = 5'(RAS_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_instr_valid;
  logic        r_busy;
  logic [4:0]  r_ras_count;
  logic        r_ras_overflow;
  logic        r_ras_underflow;
  logic [31:0] r_ras [RAS_DEPTH];

  logic          w_commit;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [31:0]   w_pc_inc;
  logic [31:0]   w_next_pc;
  logic [4:0]    w_cnt_m1;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_push_idx;

  assign w_pc_inc   = r_pc + 32'd1;
  assign w_commit   = (r_state == HOLD) && pc_update && !stall;
  assign w_pop      = (pc_src == 2'b11);
  assign w_empty    = (r_ras_count == 5'd0);
  assign w_full     = (r_ras_count == DEPTH);
  assign w_cnt_m1   = r_ras_count - 5'd1;
  assign w_top_idx  = w_cnt_m1[AW-1:0];
  assign w_push_idx = r_ras_count[AW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    if (!stall) begin
      unique case (r_state)
        IDLE:  if (fetch_req) w_state_nxt = FETCH;
        FETCH: w_state_nxt = LATCH;
        LATCH: w_state_nxt = HOLD;
        HOLD:  if (pc_update) w_state_nxt = fetch_req ? FETCH : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Popping an empty stack falls back to the sequential PC.
  always_comb begin
    w_next_pc = w_pc_inc;
    unique case (pc_src)
      2'b00: w_next_pc = w_pc_inc;
      2'b01: w_next_pc = branch_target;
      2'b10: w_next_pc = jump_target;
      2'b11: w_next_pc = w_empty ? w_pc_inc : r_ras[w_top_idx];
      default: w_next_pc = w_pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_pc            <= RESET_PC;
      r_ir            <= '0;
      r_instr_valid   <= 1'b0;
      r_busy          <= 1'b0;
      r_ras_count     <= '0;
      r_ras_overflow  <= 1'b0;
      r_ras_underflow <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_instr_valid <= (w_state_nxt == HOLD);
      r_busy        <= (w_state_nxt == FETCH) || (w_state_nxt == LATCH);
      if (r_state == LATCH && !stall) r_ir <= imem_data;
      if (w_commit) begin
        r_pc <= w_next_pc;
        if (w_pop) begin
          if (w_empty) begin
            r_ras_underflow <= 1'b1;
            if (push_ret) begin
              r_ras['0]   <= w_pc_inc;
              r_ras_count <= 5'd1;
            end
          end else if (push_ret) begin
            // Pop+push: top is consumed and replaced in place, depth unchanged.
            r_ras[w_top_idx] <= w_pc_inc;
          end else begin
            r_ras_count <= w_cnt_m1;
          end
        end else if (push_ret) begin
          if (w_full) begin
            r_ras_overflow <= 1'b1;
          end else begin
            r_ras[w_push_idx] <= w_pc_inc;
            r_ras_count       <= r_ras_count + 5'd1;
          end
        end
      end
    end
  end

  assign imem_addr     = r_pc;
  assign pc            = r_pc;
  assign ir            = r_ir;
  assign instr_valid   = r_instr_valid;
  assign busy          = r_busy;
  assign ras_count     = r_ras_count;
  assign ras_overflow  = r_ras_overflow;
  assign ras_underflow = r_ras_underflow;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; memory word i holds 32'hA000_0000 + i.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        stall = 1'b0;
  logic        pc_update = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        push_ret = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        instr_valid;
  logic        busy;
  logic [4:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'hA000_0000 + imem_addr;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .RAS_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .stall(stall),
    .pc_update(pc_update), .pc_src(pc_src), .push_ret(push_ret),
    .branch_target(branch_target), .jump_target(jump_target),
    .imem_data(imem_data), .imem_addr(imem_addr), .pc(pc), .ir(ir),
    .instr_valid(instr_valid), .busy(busy), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commit a next PC from HOLD with fetch_req high, then run to the next HOLD.
  task automatic step(input logic [1:0] src, input logic push, input logic [31:0] tgt);
    pc_update = 1'b1; pc_src = src; push_ret = push; fetch_req = 1'b1;
    branch_target = tgt; jump_target = tgt;
    tick();
    pc_update = 1'b0; push_ret = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    tests++; if (pc !== 32'd0) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0); end
    tests++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'd0); end
    tests++; if (ir !== 32'd0) begin fails++; $display("FAIL reset_ir: got %h expected %h", ir, 32'd0); end
    tests++; if ({instr_valid, busy} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b expected 00", {instr_valid, busy}); end
    tests++; if (ras_count !== 5'd0) begin fails++; $display("FAIL reset_ras: got %0d expected 0", ras_count); end
    reset = 1'b0;
    tick(); tick(); tick();
    tests++; if ({instr_valid, busy} !== 2'b00) begin fails++; $display("FAIL idle_no_req: got %b expected 00", {instr_valid, busy}); end
  endtask

  task automatic test_sequential();
    fetch_req = 1'b1;
    tick();
    tests++; if ({instr_valid, busy} !== 2'b01) begin fails++; $display("FAIL seq_fetch_state: got %b expected 01", {instr_valid, busy}); end
    tick();
    tests++; if ({instr_valid, busy} !== 2'b01) begin fails++; $display("FAIL seq_latch_state: got %b expected 01", {instr_valid, busy}); end
    tick();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_ir;
      exp_ir = 32'hA000_0000 + 32'(i);
      tests++; if (ir !== exp_ir) begin fails++; $display("FAIL seq_ir%0d: got %h expected %h", i, ir, exp_ir); end
      tests++; if ({instr_valid, busy} !== 2'b10) begin fails++; $display("FAIL seq_hold%0d: got %b expected 10", i, {instr_valid, busy}); end
      step(2'b00, 1'b0, 32'd0);
    end
    fetch_req = 1'b0; pc_update = 1'b1; pc_src = 2'b00;
    tick();
    pc_update = 1'b0;
    tests++; if (pc !== 32'd4) begin fails++; $display("FAIL seq_last_pc: got %h expected %h", pc, 32'd4); end
    tests++; if ({instr_valid, busy} !== 2'b00) begin fails++; $display("FAIL seq_to_idle: got %b expected 00", {instr_valid, busy}); end
  endtask

  task automatic test_call_return();
    fetch_req = 1'b1; tick(); tick(); tick();
    step(2'b10, 1'b0, 32'd5);
    tests++; if (ir !== 32'hA000_0005) begin fails++; $display("FAIL call_pre_ir: got %h expected %h", ir, 32'hA000_0005); end
    step(2'b10, 1'b1, 32'd40);
    tests++; if (pc !== 32'd40) begin fails++; $display("FAIL call_pc: got %h expected %h", pc, 32'd40); end
    tests++; if (ras_count !== 5'd1) begin fails++; $display("FAIL call_ras: got %0d expected 1", ras_count); end
    step(2'b00, 1'b0, 32'd0);
    step(2'b11, 1'b0, 32'd0);
    tests++; if (pc !== 32'd6) begin fails++; $display("FAIL ret_pc: got %h expected %h", pc, 32'd6); end
    tests++; if (ras_count !== 5'd0) begin fails++; $display("FAIL ret_ras: got %0d expected 0", ras_count); end
    tests++; if ({ras_overflow, ras_underflow} !== 2'b00) begin fails++; $display("FAIL ret_sticky: got %b expected 00", {ras_overflow, ras_underflow}); end
  endtask

  task automatic test_overflow_underflow();
    // pc=6: pushes store 7..14, ninth push (15) is dropped
    for (int k = 1; k <= 9; k++) begin
      step(2'b00, 1'b1, 32'd0);
      if (k == 8) begin
        tests++; if ({ras_count, ras_overflow} !== {5'd8, 1'b0}) begin fails++; $display("FAIL push8: got %0d/%b expected 8/0", ras_count, ras_overflow); end
      end
    end
    tests++; if ({ras_count, ras_overflow} !== {5'd8, 1'b1}) begin fails++; $display("FAIL push9: got %0d/%b expected 8/1", ras_count, ras_overflow); end
    tests++; if (pc !== 32'd15) begin fails++; $display("FAIL push9_pc: got %h expected %h", pc, 32'd15); end
    step(2'b10, 1'b0, 32'd100);
    for (int k = 1; k <= 8; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'd15 - 32'(k);
      step(2'b11, 1'b0, 32'd0);
      tests++; if (pc !== exp_pc || ras_count !== 5'(8 - k)) begin fails++; $display("FAIL pop%0d: got pc %h cnt %0d expected pc %h cnt %0d", k, pc, ras_count, exp_pc, 8 - k); end
    end
    tests++; if (ras_underflow !== 1'b0) begin fails++; $display("FAIL pop8_unf: got %b expected 0", ras_underflow); end
    step(2'b11, 1'b0, 32'd0);
    tests++; if (pc !== 32'd8) begin fails++; $display("FAIL pop9_pc: got %h expected %h", pc, 32'd8); end
    tests++; if ({ras_count, ras_overflow, ras_underflow} !== {5'd0, 1'b1, 1'b1}) begin fails++; $display("FAIL pop9_flags: got %0d/%b/%b expected 0/1/1", ras_count, ras_overflow, ras_underflow); end
  endtask

  task automatic test_pop_push();
    step(2'b11, 1'b1, 32'd0);
    tests++; if (pc !== 32'd9 || ras_count !== 5'd1) begin fails++; $display("FAIL poppush_empty: got pc %h cnt %0d expected pc %h cnt 1", pc, ras_count, 32'd9); end
    step(2'b11, 1'b1, 32'd0);
    tests++; if (pc !== 32'd9 || ras_count !== 5'd1) begin fails++; $display("FAIL poppush_one: got pc %h cnt %0d expected pc %h cnt 1", pc, ras_count, 32'd9); end
    step(2'b11, 1'b0, 32'd0);
    tests++; if (pc !== 32'd10 || ras_count !== 5'd0) begin fails++; $display("FAIL poppush_top: got pc %h cnt %0d expected pc %h cnt 0", pc, ras_count, 32'd10); end
  endtask

  task automatic test_update_ignored();
    pc_update = 1'b1; pc_src = 2'b00; fetch_req = 1'b1;
    tick();
    pc_src = 2'b10; jump_target = 32'd77; push_ret = 1'b1;
    tick(); tick();
    pc_update = 1'b0; push_ret = 1'b0;
    tests++; if (pc !== 32'd11 || ras_count !== 5'd0) begin fails++; $display("FAIL upd_ignored: got pc %h cnt %0d expected pc %h cnt 0", pc, ras_count, 32'd11); end
    tests++; if (ir !== 32'hA000_000B || instr_valid !== 1'b1) begin fails++; $display("FAIL upd_ir: got %h/%b expected %h/1", ir, instr_valid, 32'hA000_000B); end
  endtask

  task automatic test_stall();
    pc_update = 1'b1; pc_src = 2'b00; fetch_req = 1'b1;
    tick();
    pc_update = 1'b0;
    stall = 1'b1; pc_update = 1'b1; pc_src = 2'b10; jump_target = 32'd200; push_ret = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (pc !== 32'd12 || ir !== 32'hA000_000B || busy !== 1'b1) begin fails++; $display("FAIL stall%0d: got pc %h ir %h busy %b expected pc %h ir %h busy 1", k, pc, ir, busy, 32'd12, 32'hA000_000B); end
    end
    stall = 1'b0; pc_update = 1'b0; push_ret = 1'b0;
    tick();
    tests++; if (ir !== 32'hA000_000B || {instr_valid, busy} !== 2'b01) begin fails++; $display("FAIL stall_rel1: got ir %h flags %b expected ir %h flags 01", ir, {instr_valid, busy}, 32'hA000_000B); end
    tick();
    tests++; if (ir !== 32'hA000_000C || instr_valid !== 1'b1) begin fails++; $display("FAIL stall_rel2: got ir %h iv %b expected ir %h iv 1", ir, instr_valid, 32'hA000_000C); end
    stall = 1'b1; pc_update = 1'b1; pc_src = 2'b10; jump_target = 32'd300; push_ret = 1'b1;
    tick();
    stall = 1'b0; pc_update = 1'b0; push_ret = 1'b0;
    tests++; if (pc !== 32'd12 || ras_count !== 5'd0 || instr_valid !== 1'b1) begin fails++; $display("FAIL stall_hold: got pc %h cnt %0d iv %b expected pc %h cnt 0 iv 1", pc, ras_count, instr_valid, 32'd12); end
  endtask

  task automatic test_reset_midfetch();
    pc_update = 1'b1; pc_src = 2'b10; jump_target = 32'd40; fetch_req = 1'b1;
    tick();
    pc_update = 1'b0;
    tick();
    tests++; if (pc !== 32'd40 || busy !== 1'b1) begin fails++; $display("FAIL mid_pre: got pc %h busy %b expected pc %h busy 1", pc, busy, 32'd40); end
    reset = 1'b1; stall = 1'b1;
    tick();
    tests++; if (pc !== 32'd0 || ir !== 32'd0) begin fails++; $display("FAIL mid_pc_ir: got pc %h ir %h expected 0/0", pc, ir); end
    tests++; if ({instr_valid, busy, ras_overflow, ras_underflow} !== 4'b0000) begin fails++; $display("FAIL mid_flags: got %b expected 0000", {instr_valid, busy, ras_overflow, ras_underflow}); end
    reset = 1'b0; stall = 1'b0; fetch_req = 1'b0;
    tick(); tick();
    tests++; if (busy !== 1'b0 || pc !== 32'd0) begin fails++; $display("FAIL post_reset_idle: got busy %b pc %h expected busy 0 pc 0", busy, pc); end
  endtask

  task automatic test_wrap();
    fetch_req = 1'b1; tick(); tick(); tick();
    step(2'b01, 1'b0, 32'hFFFF_FFFF);
    tests++; if (pc !== 32'hFFFF_FFFF || ir !== 32'h9FFF_FFFF) begin fails++; $display("FAIL branch_max: got pc %h ir %h expected pc %h ir %h", pc, ir, 32'hFFFF_FFFF, 32'h9FFF_FFFF); end
    step(2'b00, 1'b0, 32'd0);
    tests++; if (pc !== 32'd0 || ir !== 32'hA000_0000) begin fails++; $display("FAIL pc_wrap: got pc %h ir %h expected pc 0 ir %h", pc, ir, 32'hA000_0000); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_return();
    test_overflow_underflow();
    test_pop_push();
    test_update_ignored();
    test_stall();
    test_reset_midfetch();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
